// File: rtl/mem_dualport_pipe.sv
// Byte-addressed big-endian unified memory: port I word fetch, port D byte/half/word
// load/store, fixed LATENCY response pipeline, alignment and range error reporting.
module mem_dualport_pipe #(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       SIZE    = 'h100000,
    parameter logic [ADDR_W-1:0] OFFSET  = 'h80020000,
    parameter int unsigned       LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);
    localparam int unsigned IW  = $clog2(SIZE);
    localparam int unsigned AW1 = ADDR_W + 1;

    function automatic logic [2:0] f_nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // End of access computed one bit wider so idx + n cannot wrap.
    function automatic logic f_err(input logic [ADDR_W-1:0] addr, input logic [1:0] sz);
        logic [AW1-1:0] end_pos;
        end_pos = {1'b0, addr - OFFSET} + AW1'(f_nbytes(sz));
        return (addr < OFFSET) || (end_pos > AW1'(SIZE)) || (sz == 2'b11) ||
               (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    endfunction

    logic [7:0]       r_mem [SIZE];
    logic             w_i_err, w_d_err, w_st, w_d_sign;
    logic [IW-1:0]    w_i_base, w_d_base;
    logic [2:0]       w_d_n;
    logic [3:0][7:0]  w_sb, w_ib, w_db;
    logic [31:0]      w_i_rdata, w_d_rdata;

    assign w_i_err  = f_err(i_addr, 2'b10);
    assign w_d_err  = f_err(d_addr, d_size);
    assign w_i_base = IW'(i_addr - OFFSET);
    assign w_d_base = IW'(d_addr - OFFSET);
    assign w_d_n    = f_nbytes(d_size);
    assign w_st     = d_req && d_write && !w_d_err;

    // Store bytes in memory order: w_sb[0] lands at idx.
    always_comb begin
        w_sb = '0;
        case (d_size)
            2'b00:   w_sb[0] = d_wdata[7:0];
            2'b01:   begin w_sb[0] = d_wdata[15:8]; w_sb[1] = d_wdata[7:0]; end
            default: begin
                w_sb[0] = d_wdata[31:24]; w_sb[1] = d_wdata[23:16];
                w_sb[2] = d_wdata[15:8];  w_sb[3] = d_wdata[7:0];
            end
        endcase
    end

    // Fetch bytes hit by a same-edge store take the new data (write-first).
    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [IW-1:0] w_ia, w_rel;
        assign w_ia     = w_i_base + IW'(k);
        assign w_rel    = w_ia - w_d_base;
        assign w_ib[k]  = (w_st && w_rel < IW'(w_d_n)) ? w_sb[w_rel[1:0]] : r_mem[w_ia];
        assign w_db[k]  = r_mem[w_d_base + IW'(k)];
    end

    assign w_i_rdata = w_i_err ? 32'h0 : {w_ib[0], w_ib[1], w_ib[2], w_ib[3]};
    assign w_d_sign  = !d_unsigned && w_db[0][7];

    always_comb begin
        case (d_size)
            2'b00:   w_d_rdata = {{24{w_d_sign}}, w_db[0]};
            2'b01:   w_d_rdata = {{16{w_d_sign}}, w_db[0], w_db[1]};
            default: w_d_rdata = {w_db[0], w_db[1], w_db[2], w_db[3]};
        endcase
        if (w_d_err || d_write) w_d_rdata = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_st) begin
            for (int j = 0; j < 4; j++)
                if (3'(j) < w_d_n) r_mem[w_d_base + IW'(j)] <= w_sb[j];
        end
    end

    logic [LATENCY-1:0]       r_i_vld, r_i_err, r_d_vld, r_d_err;
    logic [LATENCY-1:0][31:0] r_i_data, r_d_data;

    // Stage contents are zeroed when not valid so outputs idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_vld  <= '0;
            r_i_err  <= '0;
            r_i_data <= '0;
            r_d_vld  <= '0;
            r_d_err  <= '0;
            r_d_data <= '0;
        end else begin
            r_i_vld[0]  <= i_req;
            r_i_err[0]  <= i_req && w_i_err;
            r_i_data[0] <= i_req ? w_i_rdata : 32'h0;
            r_d_vld[0]  <= d_req;
            r_d_err[0]  <= d_req && w_d_err;
            r_d_data[0] <= d_req ? w_d_rdata : 32'h0;
            for (int s = 1; s < LATENCY; s++) begin
                r_i_vld[s]  <= r_i_vld[s-1];
                r_i_err[s]  <= r_i_err[s-1];
                r_i_data[s] <= r_i_data[s-1];
                r_d_vld[s]  <= r_d_vld[s-1];
                r_d_err[s]  <= r_d_err[s-1];
                r_d_data[s] <= r_d_data[s-1];
            end
        end
    end

    assign i_valid = r_i_vld[LATENCY-1];
    assign i_err   = r_i_err[LATENCY-1];
    assign i_rdata = r_i_data[LATENCY-1];
    assign d_valid = r_d_vld[LATENCY-1];
    assign d_err   = r_d_err[LATENCY-1];
    assign d_rdata = r_d_data[LATENCY-1];
endmodule

// File: tb/tb_mem_dualport_pipe.sv
// Randomized bench: four copies (LATENCY 1..4) share stimulus and are checked against
// a byte-level reference memory indexed by acceptance edge.
module tb_mem_dualport_pipe;
    localparam int unsigned SIZE   = 'h100000;
    localparam logic [31:0] OFFSET = 32'h80020000;
    localparam int          NC     = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0, d_write = 0, d_unsigned = 0;
    logic [1:0]  d_size = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;

    logic        iv [4], ie [4], dv [4], de [4];
    logic [31:0] ird [4], drd [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_dualport_pipe #(.SIZE(SIZE), .OFFSET(OFFSET), .LATENCY(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .i_req(i_req), .i_addr(i_addr), .i_valid(iv[g]), .i_rdata(ird[g]), .i_err(ie[g]),
            .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_unsigned(d_unsigned),
            .d_addr(d_addr), .d_wdata(d_wdata),
            .d_valid(dv[g]), .d_rdata(drd[g]), .d_err(de[g])
        );
    end

    int n_tests = 0, n_fail = 0;
    int ec = 0;

    // Expected response per acceptance edge number
    bit          av_i [NC], ae_i [NC], av_d [NC], ae_d [NC];
    logic [31:0] ad_i [NC], ad_d [NC];
    logic [7:0]  mm [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output bit err, output logic [31:0] rd);
        int n;
        longint idx;
        logic [31:0] val;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        idx = longint'(addr) - longint'(OFFSET);
        err = (sz == 2'd3) || (idx < 0) || (idx + n > longint'(SIZE)) || (addr % 32'(n) != 0);
        rd  = 32'h0;
        if (err) return;
        if (wr) begin
            for (int j = 0; j < n; j++) mm[addr + 32'(j)] = 8'(wd >> (8 * (n - 1 - j)));
            return;
        end
        val = 32'h0;
        for (int j = 0; j < n; j++) val = (val << 8) | 32'(mm[addr + 32'(j)]);
        if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
        rd = val;
    endfunction

    task automatic check_outs();
        for (int l = 1; l <= 4; l++) begin
            int a;
            bit vi, vd;
            a  = ec - l + 1;
            vi = (a >= 1) && av_i[a];
            vd = (a >= 1) && av_d[a];
            chk($sformatf("i_valid L%0d e%0d", l, ec), 32'(iv[l-1]), 32'(vi));
            chk($sformatf("i_rdata L%0d e%0d", l, ec), ird[l-1], vi ? ad_i[a] : 32'h0);
            chk($sformatf("i_err L%0d e%0d", l, ec), 32'(ie[l-1]), vi ? 32'(ae_i[a]) : 32'h0);
            chk($sformatf("d_valid L%0d e%0d", l, ec), 32'(dv[l-1]), 32'(vd));
            chk($sformatf("d_rdata L%0d e%0d", l, ec), drd[l-1], vd ? ad_d[a] : 32'h0);
            chk($sformatf("d_err L%0d e%0d", l, ec), 32'(de[l-1]), vd ? 32'(ae_d[a]) : 32'h0);
        end
    endtask

    task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [1:0] ds, input bit du, input logic [31:0] da,
                         input logic [31:0] dd);
        bit e;
        logic [31:0] r;
        i_req = ir; i_addr = ia; d_req = dr; d_write = dw;
        d_size = ds; d_unsigned = du; d_addr = da; d_wdata = dd;
        av_i[ec+1] = 0; ae_i[ec+1] = 0; ad_i[ec+1] = 0;
        av_d[ec+1] = 0; ae_d[ec+1] = 0; ad_d[ec+1] = 0;
        if (rst_n) begin
            // Port D first so a same-edge store is visible to the fetch
            if (dr) begin
                model(dw, ds, du, da, dd, e, r);
                av_d[ec+1] = 1; ae_d[ec+1] = e; ad_d[ec+1] = r;
            end
            if (ir) begin
                model(1'b0, 2'd2, 1'b0, ia, 32'h0, e, r);
                av_i[ec+1] = 1; ae_i[ec+1] = e; ad_i[ec+1] = r;
            end
        end
        @(posedge clk);
        ec++;
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        cycle(0, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    endtask
    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        cycle(0, 32'h0, 1, 1, sz, 0, a, wd);
    endtask
    task automatic ld(input logic [1:0] sz, input bit u, input logic [31:0] a);
        cycle(0, 32'h0, 1, 0, sz, u, a, 32'h0);
    endtask

    initial begin
        idle();
        idle();
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) st(2'd2, OFFSET + 32'(4 * w), $urandom);
        st(2'd2, OFFSET + SIZE - 4, $urandom);

        st(2'd2, 32'h80020010, 32'hDEADBEEF);
        ld(2'd2, 0, 32'h80020010); chk("word load", drd[0], 32'hDEADBEEF);
        ld(2'd0, 0, 32'h80020010); chk("byte +0 signed", drd[0], 32'hFFFFFFDE);
        ld(2'd0, 1, 32'h80020013); chk("byte +3 unsigned", drd[0], 32'h000000EF);

        st(2'd1, 32'h80020020, 32'h00008001);
        st(2'd0, 32'h80020022, 32'h0000007F);
        ld(2'd1, 0, 32'h80020020); chk("half signed", drd[0], 32'hFFFF8001);
        ld(2'd2, 0, 32'h80020020); chk("word 80017F", 32'(drd[0] >> 8), 32'h0080017F);

        ld(2'd1, 0, 32'h80020001); chk("err half misalign", 32'(de[0]), 32'h1);
        ld(2'd2, 0, 32'h80020002); chk("err word misalign", 32'(de[0]), 32'h1);
        ld(2'd2, 0, 32'h8001FFFC); chk("err below", 32'(de[0]), 32'h1);
        ld(2'd2, 0, OFFSET + SIZE - 2); chk("err top", 32'(de[0]), 32'h1);
        ld(2'd3, 0, 32'h80020000); chk("err size11", 32'(de[0]), 32'h1);
        ld(2'd2, 0, OFFSET + SIZE - 4); chk("top word ok", 32'(de[0]), 32'h0);
        st(2'd2, 32'h80020006, 32'hCAFEF00D);
        ld(2'd2, 0, 32'h80020004);

        cycle(1, 32'h80020040, 1, 1, 2'd2, 0, 32'h80020040, 32'h12345678);
        chk("collision fetch", ird[0], 32'h12345678);

        for (int k = 0; k < 10; k++) cycle(1, OFFSET + 32'(4 * k), 0, 0, 2'd0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) ld(2'd2, 0, OFFSET + 32'(4 * k));
        idle();

        // Async reset with two requests in flight
        cycle(1, 32'h80020010, 1, 0, 2'd2, 0, 32'h80020010, 32'h0);
        cycle(1, 32'h80020014, 1, 0, 2'd2, 0, 32'h80020014, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("rst i_valid L%0d", l + 1), 32'(iv[l]), 32'h0);
            chk($sformatf("rst d_valid L%0d", l + 1), 32'(dv[l]), 32'h0);
            chk($sformatf("rst i_rdata L%0d", l + 1), ird[l], 32'h0);
            chk($sformatf("rst d_rdata L%0d", l + 1), drd[l], 32'h0);
            chk($sformatf("rst errs L%0d", l + 1), 32'({ie[l], de[l]}), 32'h0);
        end
        for (int a = 0; a <= ec; a++) begin av_i[a] = 0; av_d[a] = 0; end
        cycle(1, 32'h80020018, 1, 0, 2'd2, 0, 32'h80020018, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) idle();

        for (int k = 0; k < 600; k++) begin
            logic [31:0] ia, da;
            ia = OFFSET + $urandom_range(0, 255);
            da = OFFSET + $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) da = ($urandom_range(0, 1) == 1) ? OFFSET - 4 : OFFSET + SIZE - 2;
            if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
            cycle($urandom_range(0, 1) == 1, ia, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, da, $urandom);
        end
        for (int k = 0; k < 6; k++) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_dualport_pipe.md
Name: mem_dualport_pipe

Overview:
- Parametrised, byte-addressed, big-endian unified memory for the pipelined processor.
- Serves two independent ports in one clock domain:
  - port I: read-only instruction fetch, word access.
  - port D: load/store with byte/halfword/word access.
- Fixed, parameterised read latency; load sign/zero extension; misalignment and out-of-range error reporting.
- Sits between fetch/memory stages and the testbench program loader.

Parameters:
- SIZE, 'h100000, memory depth in bytes (1 MB).
- OFFSET, 'h80020000, byte address mapped to memory index 0.
- LATENCY, 1, cycles from request acceptance to response valid (1..4).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  port I fetch request, accepted every cycle it is high.
- i_addr  in  ADDR_W  port I byte address.
- i_valid  out  1  port I response valid.
- i_rdata  out  32  port I fetched word, big-endian.
- i_err  out  1  port I error, qualified by i_valid.
- d_req  in  1  port D request.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- d_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- d_addr  in  ADDR_W  port D byte address.
- d_wdata  in  32  store data, right-aligned (byte = [7:0], half = [15:0]).
- d_valid  out  1  port D response valid; for loads and stores.
- d_rdata  out  32  load result; 0 for stores.
- d_err  out  1  port D error, qualified by d_valid.

Behaviour:
- Reset (rst_n low, async):
  - i_valid, d_valid, i_err, d_err go to 0.
  - i_rdata and d_rdata go to 0.
  - All latency pipeline stages are cleared.
  - Memory array contents are not reset.
  - Requests in flight at reset are dropped; no response is produced for them.
- Acceptance:
  - No backpressure. A request is accepted on every rising edge where its req is high and rst_n is high.
  - Both ports are fully pipelined: one new request per port per cycle.
- Latency:
  - The response for a request accepted at edge N appears after edge N+LATENCY-1 and holds for exactly one cycle.
  - LATENCY=1 means valid is asserted in the cycle immediately after acceptance.
  - Responses are returned in order per port.
- Index: idx = addr - OFFSET, computed at ADDR_W width.
- Byte count: n = 1, 2 or 4 for d_size 00, 01 or 10. Port I always uses n = 4.
- Error conditions (any one sets err):
  - addr < OFFSET.
  - idx + n > SIZE.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - d_size = 11.
- On error: stores do not modify memory; loads return rdata = 0; valid is still asserted.
- Store (big-endian):
  - Word: mem[idx..idx+3] = wdata[31:24], [23:16], [15:8], [7:0].
  - Half: mem[idx], mem[idx+1] = wdata[15:8], [7:0].
  - Byte: mem[idx] = wdata[7:0].
  - Memory is written at the acceptance edge.
- Load:
  - Bytes are assembled big-endian and right-aligned.
  - Upper bits are filled with the sign bit (d_unsigned = 0) or zeros (d_unsigned = 1).
  - Word loads ignore d_unsigned.
- Collision: a port D store and a read (port I, or port D on a later cycle) to overlapping bytes accepted on the same edge are write-first; the read returns the newly written bytes.
- Reads sample memory at acceptance. Data then travels through the LATENCY pipeline; it is not re-read later.
- Outputs while valid is low: rdata and err hold 0.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream with 2 requests in flight (LATENCY = 3) -> i_valid/d_valid/errs/rdatas are 0 immediately; no responses appear after release.
- Word round-trip:
  - Store word 32'hDEADBEEF at 'h80020010.
  - Load word there -> d_rdata = 32'hDEADBEEF.
  - Byte loads at +0 and +3 -> 32'hFFFFFFDE (signed) and 32'h000000EF (unsigned).
- Halfword and byte store, signed load:
  - Store half 16'h8001 at 'h80020020 and byte 8'h7F at 'h80020022.
  - Signed half load -> 32'hFFFF8001.
  - Word load -> 32'h80017FXX, where XX is the prior contents of byte idx+3.
- Error cases, each returning valid = 1, err = 1, rdata = 0:
  - Half load at 'h80020001.
  - Word load at 'h80020002.
  - Load at 'h8001FFFC.
  - Word load at OFFSET+SIZE-2.
  - d_size = 11.
  - Additionally, an errored word store at 'h80020006 leaves the word at 'h80020004 unchanged.
- Collision:
  - Same edge: port D stores 32'h12345678 at 'h80020040 while port I fetches 'h80020040 -> i_rdata = 32'h12345678.
  - Back-to-back fetches every cycle with LATENCY = 2 -> one i_valid per cycle, in order.
- Latency sweep: LATENCY = 1 and 4 -> d_valid is first asserted exactly 1 and 4 cycles after the accepting edge; continuous requests give continuous valid.
